// File: rtl/dcmac_0_axis_pkt_mon_sched_if.sv
// rtl/dcmac_0_axis_pkt_mon_sched_if.sv - per-port LBUS beat bundle between requesters and the packet scheduler
// o_pkt_cnt exists only when DCMAC_0_PKT_MON_SCHED_STATS_EN is defined.
interface dcmac_0_axis_pkt_mon_sched_if #(
  parameter int NUM_PORTS = 6
);
  localparam int PKT_W = 1635;

  logic [NUM_PORTS-1:0][PKT_W-1:0] i_pkt;
  logic [NUM_PORTS-1:0]            i_valid;
  logic [NUM_PORTS-1:0]            o_ready;
  logic                            i_pause;
  logic [PKT_W-1:0]                o_pkt;
  logic                            o_valid;
  logic [2:0]                      o_grant;
  logic                            o_proto_err;
  logic                            o_timeout;
`ifdef DCMAC_0_PKT_MON_SCHED_STATS_EN
  logic [NUM_PORTS-1:0][31:0]      o_pkt_cnt;

  modport master (
    output i_pkt, i_valid, i_pause,
    input  o_ready, o_pkt, o_valid, o_grant, o_proto_err, o_timeout, o_pkt_cnt
  );
  modport slave (
    input  i_pkt, i_valid, i_pause,
    output o_ready, o_pkt, o_valid, o_grant, o_proto_err, o_timeout, o_pkt_cnt
  );
`else
  modport master (
    output i_pkt, i_valid, i_pause,
    input  o_ready, o_pkt, o_valid, o_grant, o_proto_err, o_timeout
  );
  modport slave (
    input  i_pkt, i_valid, i_pause,
    output o_ready, o_pkt, o_valid, o_grant, o_proto_err, o_timeout
  );
`endif
endinterface

// File: rtl/dcmac_0_axis_pkt_mon_sched.sv
// rtl/dcmac_0_axis_pkt_mon_sched.sv - packet-boundary round-robin scheduler with protocol and idle-timeout monitor
// Optional per-port packet counters: DCMAC_0_PKT_MON_SCHED_STATS_EN.
module dcmac_0_axis_pkt_mon_sched #(
  parameter int NUM_PORTS = 6,
  parameter int TIMEOUT   = 1024
) (
  input logic                         clk,
  input logic                         rst_n,
  dcmac_0_axis_pkt_mon_sched_if.slave bus
);
  localparam int PKT_W   = 1635;
  localparam int NSEG    = 12;
  localparam int EOP_LSB = 1596;
  localparam int SOP_LSB = 1608;
  localparam int ENA_LSB = 1620;
  localparam int ID_LSB  = 1632;
  localparam int CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TMO_LIM = (CW + 1)'(TIMEOUT);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_grant_q, last_grant_d;
  logic [2:0]       grant_q, grant_d;
  logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic             valid_q, valid_d;
  logic             proto_err_q, proto_err_d;
  logic             timeout_q, timeout_d;

  logic [2:0]           sel;
  logic                 sel_ok;
  logic                 accept;
  logic [NUM_PORTS-1:0] ready;
  logic [PKT_W-1:0]     beat;
  logic [NSEG-1:0]      ena, sop, eop;
  logic                 bad_beat;
  logic                 open_after;
  logic [CW:0]          cnt_inc;

  // Locked: the owner keeps the bus. Idle: first valid port after last_grant, unless paused.
  always_comb begin
    int idx;
    idx    = 0;
    sel    = grant_q;
    sel_ok = 1'b0;
    if (state_q == LOCKED) begin
      sel_ok = 1'b1;
    end else if (!bus.i_pause) begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = int'(last_grant_q) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (bus.i_valid[3'(idx)]) begin
          sel    = 3'(idx);
          sel_ok = 1'b1;
        end
      end
    end
  end

  assign accept = sel_ok && bus.i_valid[sel];
  assign beat   = bus.i_pkt[sel];
  assign ena    = beat[ENA_LSB +: NSEG];
  assign sop    = beat[SOP_LSB +: NSEG] & ena;
  assign eop    = beat[EOP_LSB +: NSEG] & ena;

  always_comb begin
    ready = '0;
    if (sel_ok && rst_n) ready[sel] = bus.i_valid[sel];
  end
  assign bus.o_ready = ready;

  // Walk segments in order; the last sop/eop decides whether the beat leaves a packet open.
  always_comb begin
    logic seen_sop, seen_eop;
    seen_sop   = 1'b0;
    seen_eop   = 1'b0;
    bad_beat   = 1'b0;
    open_after = (state_q == LOCKED);
    for (int s = 0; s < NSEG; s++) begin
      if (state_q == IDLE && eop[s] && !(seen_sop || sop[s])) bad_beat = 1'b1;
      if (state_q == LOCKED && sop[s] && !seen_eop) bad_beat = 1'b1;
      if (sop[s]) seen_sop = 1'b1;
      if (eop[s]) seen_eop = 1'b1;
      if (sop[s] || eop[s]) open_after = sop[s] && !eop[s];
    end
  end

  assign cnt_inc = {1'b0, tmo_cnt_q} + (CW + 1)'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    pkt_d        = pkt_q;
    pkt_d[ENA_LSB +: NSEG] = '0;
    valid_d      = 1'b0;
    proto_err_d  = 1'b0;
    timeout_d    = 1'b0;
    if (accept) begin
      pkt_d               = beat;
      pkt_d[ID_LSB +: 3]  = sel;
      valid_d             = 1'b1;
      proto_err_d         = bad_beat;
      grant_d             = sel;
      last_grant_d        = sel;
      tmo_cnt_d           = '0;
      state_d             = open_after ? LOCKED : IDLE;
    end else if (state_q == LOCKED) begin
      if (TIMEOUT == 0) begin
        if (!(&tmo_cnt_q)) tmo_cnt_d = cnt_inc[CW-1:0];
      end else if (cnt_inc == TMO_LIM) begin
        // Forced release: the stalled owner goes to the back of the rotation.
        timeout_d    = 1'b1;
        state_d      = IDLE;
        tmo_cnt_d    = '0;
        last_grant_d = grant_q;
      end else begin
        tmo_cnt_d = cnt_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_PORTS - 1);
      grant_q      <= '0;
      tmo_cnt_q    <= '0;
      pkt_q        <= '0;
      valid_q      <= 1'b0;
      proto_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pkt_q        <= pkt_d;
      valid_q      <= valid_d;
      proto_err_q  <= proto_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.o_pkt       = pkt_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_proto_err = proto_err_q;
  assign bus.o_timeout   = timeout_q;

`ifdef DCMAC_0_PKT_MON_SCHED_STATS_EN
  logic [NUM_PORTS-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

  // One count per eop in an accepted beat, so packets closed inside a single beat are included.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (accept) pkt_cnt_d[sel] = pkt_cnt_q[sel] + 32'($countones(eop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign bus.o_pkt_cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_sched.sv
// tb/tb_dcmac_0_axis_pkt_mon_sched.sv - directed vector bench for dcmac_0_axis_pkt_mon_sched
module tb_dcmac_0_axis_pkt_mon_sched;
  localparam int NP      = 6;
  localparam int TMO     = 8;
  localparam int PKT_W   = 1635;
  localparam int MTY_LSB = 1536;
  localparam int EOP_LSB = 1596;
  localparam int SOP_LSB = 1608;
  localparam int ENA_LSB = 1620;
  localparam int ID_LSB  = 1632;

  localparam logic [2:0] K0 = 3'd0;
  localparam logic [2:0] KS = 3'd1;
  localparam logic [2:0] KO = 3'd2;
  localparam logic [2:0] KM = 3'd3;
  localparam logic [2:0] KC = 3'd4;
  localparam logic [2:0] KB = 3'd5;
  localparam logic [2:0] KX = 3'd6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcmac_0_axis_pkt_mon_sched_if #(.NUM_PORTS(NP)) bus ();

  dcmac_0_axis_pkt_mon_sched #(
    .NUM_PORTS(NP),
    .TIMEOUT  (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [NP-1:0]      valid;
    logic               pause;
    logic [NP-1:0][2:0] kind;
    logic [NP-1:0]      exp_ready;
    logic               exp_valid;
    logic [2:0]         exp_grant;
    logic               exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [PKT_W-1:0] mk_beat(input int port, input logic [2:0] kind, input int tag);
    logic [PKT_W-1:0] b;
    logic [11:0] ena, sop, eop;
    b = '0; ena = '0; sop = '0; eop = '0;
    case (kind)
      KS: begin ena = 12'h03f; sop = 12'h001; eop = 12'h020; end
      KO: begin ena = 12'hfff; sop = 12'h010; end
      KM: begin ena = 12'hfff; end
      KC: begin ena = 12'h07f; eop = 12'h040; end
      KB: begin ena = 12'h03f; eop = 12'h004; end
      KX: begin ena = 12'h0ff; sop = 12'h021; eop = 12'h004; end
      default: ;
    endcase
    b[31:0]            = 32'(tag);
    b[39:32]           = 8'(port);
    b[MTY_LSB +: 4]    = {1'b0, kind};
    b[ENA_LSB +: 12]   = ena;
    b[SOP_LSB +: 12]   = sop;
    b[EOP_LSB +: 12]   = eop;
    b[ID_LSB +: 3]     = ~3'(port);
    return b;
  endfunction

  function automatic logic [PKT_W-1:0] exp_out(input int port, input logic [2:0] kind, input int tag);
    logic [PKT_W-1:0] b;
    b = mk_beat(port, kind, tag);
    b[ID_LSB +: 3] = 3'(port);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input logic [PKT_W-1:0] exp);
    n_chk++;
    if (bus.o_pkt !== exp) begin
      n_fail++;
      $display("FAIL %s: got id %0h tag %0h ena %0h expected id %0h tag %0h ena %0h", name,
               bus.o_pkt[ID_LSB +: 3], bus.o_pkt[31:0], bus.o_pkt[ENA_LSB +: 12],
               exp[ID_LSB +: 3], exp[31:0], exp[ENA_LSB +: 12]);
    end
  endtask

  task automatic add(input logic [NP-1:0] valid, input logic pause, input logic [NP-1:0][2:0] kind,
                     input logic [NP-1:0] exp_ready, input logic exp_valid, input logic [2:0] exp_grant,
                     input logic exp_err);
    vec_t v;
    v.valid = valid; v.pause = pause; v.kind = kind; v.exp_ready = exp_ready;
    v.exp_valid = exp_valid; v.exp_grant = exp_grant; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    bus.i_valid = '0;
    bus.i_pause = 1'b0;
    for (int p = 0; p < NP; p++) bus.i_pkt[p] = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    clear_inputs();

    // ports 5..0 listed left to right in every vector
    add(6'b001001, 0, {K0, K0, KS, K0, K0, KS}, 6'b000001, 1, 3'd0, 0);
    add(6'b001001, 0, {K0, K0, KS, K0, K0, KS}, 6'b001000, 1, 3'd3, 0);
    add(6'b001001, 0, {K0, K0, KS, K0, K0, KS}, 6'b000001, 1, 3'd0, 0);
    add(6'b001001, 0, {K0, K0, KS, K0, K0, KS}, 6'b001000, 1, 3'd3, 0);
    add(6'b000110, 0, {K0, K0, K0, KS, KO, K0}, 6'b000010, 1, 3'd1, 0);
    add(6'b000110, 0, {K0, K0, K0, KS, KM, K0}, 6'b000010, 1, 3'd1, 0);
    add(6'b000110, 0, {K0, K0, K0, KS, KC, K0}, 6'b000010, 1, 3'd1, 0);
    add(6'b000100, 0, {K0, K0, K0, KS, K0, K0}, 6'b000100, 1, 3'd2, 0);
    add(6'b010000, 0, {K0, KO, K0, K0, K0, K0}, 6'b010000, 1, 3'd4, 0);
    add(6'b010001, 1, {K0, KM, K0, K0, K0, KS}, 6'b010000, 1, 3'd4, 0);
    add(6'b010001, 1, {K0, KC, K0, K0, K0, KS}, 6'b010000, 1, 3'd4, 0);
    add(6'b000001, 1, {K0, K0, K0, K0, K0, KS}, 6'b000000, 0, 3'd4, 0);
    add(6'b000001, 1, {K0, K0, K0, K0, K0, KS}, 6'b000000, 0, 3'd4, 0);
    add(6'b000001, 0, {K0, K0, K0, K0, K0, KS}, 6'b000001, 1, 3'd0, 0);
    add(6'b000100, 0, {K0, K0, K0, KB, K0, K0}, 6'b000100, 1, 3'd2, 1);
    add(6'b001000, 0, {K0, K0, KS, K0, K0, K0}, 6'b001000, 1, 3'd3, 0);
    add(6'b100000, 0, {KO, K0, K0, K0, K0, K0}, 6'b100000, 1, 3'd5, 0);
    add(6'b100000, 0, {KO, K0, K0, K0, K0, K0}, 6'b100000, 1, 3'd5, 1);
    add(6'b100001, 0, {KC, K0, K0, K0, K0, KS}, 6'b100000, 1, 3'd5, 0);
    add(6'b000001, 0, {K0, K0, K0, K0, K0, KS}, 6'b000001, 1, 3'd0, 0);
    add(6'b000010, 0, {K0, K0, K0, K0, KX, K0}, 6'b000010, 1, 3'd1, 0);
    add(6'b000110, 0, {K0, K0, K0, KS, KC, K0}, 6'b000010, 1, 3'd1, 0);
    add(6'b000000, 0, {K0, K0, K0, K0, K0, K0}, 6'b000000, 0, 3'd1, 0);

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_grant", 64'(bus.o_grant), 64'd0);
    chk("rst_err", 64'(bus.o_proto_err), 64'd0);
    chk("rst_tmo", 64'(bus.o_timeout), 64'd0);
    chk_pkt("rst_pkt", '0);
    rst_n = 1'b1;
    #1 chk("rst_ready", 64'(bus.o_ready), 64'd0);

    foreach (vecs[i]) begin
      bus.i_valid = vecs[i].valid;
      bus.i_pause = vecs[i].pause;
      for (int p = 0; p < NP; p++) bus.i_pkt[p] = mk_beat(p, vecs[i].kind[p], i * 16 + p);
      #1 chk($sformatf("v%0d_ready", i), 64'(bus.o_ready), 64'(vecs[i].exp_ready));
      cycle();
      chk($sformatf("v%0d_valid", i), 64'(bus.o_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_grant", i), 64'(bus.o_grant), 64'(vecs[i].exp_grant));
      chk($sformatf("v%0d_err", i), 64'(bus.o_proto_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_tmo", i), 64'(bus.o_timeout), 64'd0);
      if (vecs[i].exp_valid)
        chk_pkt($sformatf("v%0d_pkt", i),
                exp_out(int'(vecs[i].exp_grant), vecs[i].kind[vecs[i].exp_grant], i * 16 + int'(vecs[i].exp_grant)));
      else
        chk($sformatf("v%0d_ena_idle", i), 64'(bus.o_pkt[ENA_LSB +: 12]), 64'd0);
    end

    // idle timeout: port 0 opens and stalls, port 1 waits
    clear_inputs();
    bus.i_valid  = 6'b000001;
    bus.i_pkt[0] = mk_beat(0, KO, 500);
    #1 chk("tmo_open_ready", 64'(bus.o_ready), 64'b000001);
    cycle();
    chk("tmo_open_valid", 64'(bus.o_valid), 64'd1);
    chk("tmo_open_grant", 64'(bus.o_grant), 64'd0);
    bus.i_valid  = 6'b000010;
    bus.i_pkt[0] = '0;
    bus.i_pkt[1] = mk_beat(1, KS, 501);
    #1 chk("tmo_locked_ready", 64'(bus.o_ready), 64'd0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      cycle();
      cyc++;
      if (bus.o_timeout) seen = 1;
      else chk($sformatf("tmo_wait%0d_ready", cyc), 64'(bus.o_ready), 64'd0);
    end
    chk("tmo_seen", 64'(seen), 64'd1);
    chk("tmo_cycles", 64'(cyc), 64'(TMO));
    chk("tmo_rearb_ready", 64'(bus.o_ready), 64'b000010);
    cycle();
    chk("tmo_pulse_end", 64'(bus.o_timeout), 64'd0);
    chk("tmo_next_valid", 64'(bus.o_valid), 64'd1);
    chk("tmo_next_grant", 64'(bus.o_grant), 64'd1);
    chk_pkt("tmo_next_pkt", exp_out(1, KS, 501));

    // reset in the middle of port 2's packet
    clear_inputs();
    bus.i_valid  = 6'b000100;
    bus.i_pkt[2] = mk_beat(2, KO, 600);
    #1 chk("mrst_open_ready", 64'(bus.o_ready), 64'b000100);
    cycle();
    chk("mrst_open_grant", 64'(bus.o_grant), 64'd2);
    bus.i_valid  = 6'b000101;
    bus.i_pkt[2] = mk_beat(2, KM, 601);
    bus.i_pkt[0] = mk_beat(0, KS, 602);
    #1 chk("mrst_locked_ready", 64'(bus.o_ready), 64'b000100);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.o_valid), 64'd0);
    chk("mrst_grant", 64'(bus.o_grant), 64'd0);
    chk("mrst_ready", 64'(bus.o_ready), 64'd0);
    chk("mrst_err", 64'(bus.o_proto_err), 64'd0);
    chk("mrst_tmo", 64'(bus.o_timeout), 64'd0);
    chk_pkt("mrst_pkt", '0);
    cycle();
    chk("mrst_hold_valid", 64'(bus.o_valid), 64'd0);
    rst_n = 1'b1;
    #1 chk("mrst_rel_ready", 64'(bus.o_ready), 64'b000001);
    cycle();
    chk("mrst_rel_valid", 64'(bus.o_valid), 64'd1);
    chk("mrst_rel_grant", 64'(bus.o_grant), 64'd0);
    chk_pkt("mrst_rel_pkt", exp_out(0, KS, 602));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcmac_0_axis_pkt_mon_sched.md
DCMAC_0_AXIS_PKT_MON_SCHED -- requirements
Module: dcmac_0_axis_pkt_mon_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 6: number of requesting ports, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 1024: idle cycles allowed inside an open packet; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_pkt  input  NUM_PORTS x 1635  per-port 12-segment LBUS beat: id 3, ena/sop/eop/err 12 each, mty 12x4, dat 12x128.
REQ-006 SHALL have port i_valid  input  NUM_PORTS  per-port beat valid.
REQ-007 SHALL have port o_ready  output  NUM_PORTS  per-port beat accepted.
REQ-008 SHALL have port i_pause  input  1  blocks new grants at packet boundaries.
REQ-009 SHALL have port o_pkt  output  1635  granted beat, same format as i_pkt, feeding the segment-compaction pipeline.
REQ-010 SHALL have port o_valid  output  1  o_pkt qualifier.
REQ-011 SHALL have port o_grant  output  3  index of the currently or last granted port.
REQ-012 SHALL have port o_proto_err  output  1  one-cycle pulse on a protocol violation.
REQ-013 SHALL have port o_timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-014 SHALL be a two-state FSM: IDLE (no open packet) and LOCKED (granted port has an open packet).
REQ-015 SHALL, in IDLE with i_pause low, grant round-robin, searching from (last_grant+1) mod NUM_PORTS, to the first port with i_valid high.
REQ-016 SHALL drive o_ready[p] high combinationally only for the granted port p while i_valid[p] is high; a beat is accepted when i_valid[p] and o_ready[p] are both high.
REQ-017 SHALL register each accepted beat into o_pkt with latency 1, set o_pkt.id to the port index, and assert o_valid for exactly that cycle.
REQ-018 SHALL force o_pkt.ena to zero whenever o_valid is low.
REQ-019 SHALL define a beat as "open-ending" when its highest-index enabled segment with sop or eop set carries sop without eop; otherwise the beat keeps the current open/closed state.
REQ-020 SHALL move IDLE to LOCKED on an accepted open-ending beat, and LOCKED to IDLE on an accepted beat whose last enabled sop/eop segment is an eop.
REQ-021 SHALL keep the grant fixed while LOCKED, ignoring i_pause and all other ports.
REQ-022 SHALL re-arbitrate in the cycle after a LOCKED-to-IDLE transition, so back-to-back packets from different ports have no bubble.
REQ-023 SHALL accept beats that open and close a packet inside one beat without entering LOCKED.
REQ-024 SHALL pulse o_proto_err and still forward the beat when: an enabled segment carries eop in IDLE with no preceding sop in that beat; or a segment carries sop in LOCKED before any eop in that beat.
REQ-025 SHALL, in LOCKED, count consecutive cycles with no accepted beat; when the count reaches TIMEOUT it SHALL pulse o_timeout, go to IDLE and advance last_grant. The counter clears on any accepted beat and saturates when TIMEOUT is 0.
REQ-026 SHALL give priority to an accepted beat over timeout expiry in the same cycle.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set the FSM to IDLE, last_grant to NUM_PORTS-1 (port 0 served first), o_grant to 0, and the timeout counter, o_valid, o_pkt, o_proto_err and o_timeout to 0.
REQ-028 SHALL, if reset occurs mid-packet, drop the open packet; no partial beat is emitted after reset release.

Configuration
REQ-029 SHALL, when DCMAC_0_PKT_MON_SCHED_STATS_EN is defined, add output o_pkt_cnt (NUM_PORTS x 32). Each counter increments on every packet close on its port, wraps at 2^32-1, and clears on reset.
REQ-030 SHALL, when DCMAC_0_PKT_MON_SCHED_STATS_EN is undefined, omit o_pkt_cnt and all its logic; the rest of the behaviour is identical.

Verification
REQ-031 SHALL cover: ports 0 and 3 valid with single-beat packets (sop[0], eop[5]) -> grants in order 0,3,0,3, o_valid every cycle, o_pkt.id matches the port.
REQ-032 SHALL cover: port 1 sends a 3-beat packet while port 2 is valid -> port 2 has o_ready low for all 3 beats and is granted in the next cycle.
REQ-033 SHALL cover: i_pause high during port 4's open packet -> the packet completes; no new grant until i_pause falls.
REQ-034 SHALL cover: TIMEOUT=8, port 0 opens a packet then i_valid drops -> o_timeout pulses 8 cycles later and port 1 is granted next.
REQ-035 SHALL cover: an IDLE beat with eop[2] only -> o_proto_err pulses once, the beat is forwarded, and the FSM stays IDLE.
REQ-036 SHALL cover: rst_n pulsed low mid-packet -> all outputs are 0 within the same cycle and port 0 is granted first after release.
